// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes used by RTL and bench.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } usr_mode_t;

endpackage

// File: rtl/usr_sat_counter.sv
// Saturating up-counter with synchronous active-low reset, clear and increment.
// at_max flags that the count has reached MAX; further increments are ignored.
module usr_sat_counter #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX+1)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          en,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    logic [CW-1:0] r_cnt;
    logic          w_at_max;

    assign w_at_max = (r_cnt == CW'(MAX));

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (en) begin
            if (clear) begin
                r_cnt <= '0;
            end else if (inc && !w_at_max) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign cnt    = r_cnt;
    assign at_max = w_at_max;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/arith-shift/clear with a saturating shift counter.
// Optional macro USR_PARITY_EN adds the parity output (XOR of q).
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    cnt,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_clear;
    logic             w_inc;

    always_comb begin
        w_q_next = r_q;
        w_clear  = 1'b0;
        w_inc    = 1'b0;
        case (usr_mode_t'(mode))
            MODE_HOLD:  w_q_next = r_q;
            MODE_LOAD: begin
                w_q_next = d;
                w_clear  = 1'b1;
            end
            MODE_SHL: begin
                w_q_next = {r_q[WIDTH-2:0], sin_r};
                w_inc    = 1'b1;
            end
            MODE_SHR: begin
                w_q_next = {sin_l, r_q[WIDTH-1:1]};
                w_inc    = 1'b1;
            end
            MODE_ROL: begin
                w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_inc    = 1'b1;
            end
            MODE_ROR: begin
                w_q_next = {r_q[0], r_q[WIDTH-1:1]};
                w_inc    = 1'b1;
            end
            MODE_ASR: begin
                w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_inc    = 1'b1;
            end
            MODE_CLEAR: begin
                w_q_next = '0;
                w_clear  = 1'b1;
            end
            default:    w_q_next = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= w_q_next;
        end
    end

    // Counter shares clr_n/en priority with the data register so both always move together.
    usr_sat_counter #(
        .MAX (WIDTH),
        .CW  (CW)
    ) u_cnt (
        .clk    (clk),
        .clr_n  (clr_n),
        .en     (en),
        .clear  (w_clear),
        .inc    (w_inc),
        .cnt    (cnt),
        .at_max (done)
    );

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];

`ifdef USR_PARITY_EN
    assign parity = ^r_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: directed vectors push expected state, a monitor pops and checks each cycle.
module tb_univ_shift_reg;
    import usr_pkg::*;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH+1);

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [CW-1:0]    cnt;
        logic             par;
        string            name;
    } exp_t;

    logic             clk = 1'b0;
    logic             clr_n = 1'b0;
    logic             en = 1'b0;
    logic [2:0]       mode = 3'b000;
    logic [WIDTH-1:0] d = '0;
    logic             sin_l = 1'b0;
    logic             sin_r = 1'b0;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic [CW-1:0]    cnt;
    logic             done;
`ifdef USR_PARITY_EN
    logic             parity;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
`ifdef USR_PARITY_EN
        .parity (parity),
`endif
        .clk    (clk),
        .clr_n  (clr_n),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .cnt    (cnt),
        .done   (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Drive one operation at the falling edge and record what must appear after the next rising edge.
    task automatic step(input logic rn, input logic e, input usr_mode_t m, input logic [WIDTH-1:0] dd,
                        input logic sl, input logic sr, input logic [WIDTH-1:0] eq,
                        input logic [CW-1:0] ec, input logic ep, input string nm);
        exp_t x;
        @(negedge clk);
        clr_n = rn;
        en    = e;
        mode  = m;
        d     = dd;
        sin_l = sl;
        sin_r = sr;
        x.q    = eq;
        x.cnt  = ec;
        x.par  = ep;
        x.name = nm;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk({x.name, ".q"},      32'(q),      32'(x.q));
                chk({x.name, ".cnt"},    32'(cnt),    32'(x.cnt));
                chk({x.name, ".done"},   32'(done),   32'(x.cnt == CW'(WIDTH)));
                chk({x.name, ".sout_l"}, 32'(sout_l), 32'(x.q[WIDTH-1]));
                chk({x.name, ".sout_r"}, 32'(sout_r), 32'(x.q[0]));
`ifdef USR_PARITY_EN
                chk({x.name, ".parity"}, 32'(parity), 32'(x.par));
`endif
            end
        end
    end

    logic [WIDTH-1:0] shl_q [8]  = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
    logic             shr_in [10] = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic [WIDTH-1:0] shr_q [10] = '{8'h80, 8'hC0, 8'h60, 8'hB0, 8'h58, 8'h2C, 8'h96, 8'h4B, 8'hA5, 8'hD2};

    initial begin : stim
        int wait_cnt;
        // Reset dominates an enabled LOAD
        step(0, 1, MODE_LOAD, 8'hFF, 0, 0, 8'h00, 0, 0, "rst0");
        step(0, 1, MODE_LOAD, 8'hFF, 0, 0, 8'h00, 0, 0, "rst1");
        step(1, 1, MODE_LOAD, 8'hA5, 0, 0, 8'hA5, 0, 0, "load_a5");

        // Serialise A5 out of the MSB
        for (int i = 0; i < 8; i++) begin
            step(1, 1, MODE_SHL, 8'h00, 0, 0, shl_q[i], CW'(i + 1), ^shl_q[i], $sformatf("shl%0d", i));
        end

        // Deserialise from the MSB end, running past saturation
        step(1, 1, MODE_CLEAR, 8'h5A, 0, 0, 8'h00, 0, 0, "clear");
        for (int i = 0; i < 10; i++) begin
            step(1, 1, MODE_SHR, 8'h00, shr_in[i], 0, shr_q[i], (i < 8) ? CW'(i + 1) : CW'(8),
                 ^shr_q[i], $sformatf("shr%0d", i));
        end

        // Rotates and arithmetic shift; mode changes keep counting
        step(1, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0, 0, "load_81");
        step(1, 1, MODE_ROL,  8'h00, 0, 0, 8'h03, 1, 0, "rol");
        step(1, 1, MODE_ROR,  8'h00, 0, 0, 8'h81, 2, 0, "ror");
        step(1, 1, MODE_ASR,  8'h00, 0, 0, 8'hC0, 3, 0, "asr0");
        step(1, 1, MODE_ASR,  8'h00, 0, 0, 8'hE0, 4, 1, "asr1");

        // Disabled CLEAR must not act; reset still wins over en=0
        for (int i = 0; i < 3; i++) begin
            step(1, 0, MODE_CLEAR, 8'h00, 1, 1, 8'hE0, 4, 1, $sformatf("en0_%0d", i));
        end
        step(0, 0, MODE_SHL, 8'hFF, 1, 1, 8'h00, 0, 0, "rst_en0");
        step(1, 0, MODE_LOAD, 8'hFF, 1, 1, 8'h00, 0, 0, "hold_after_rst");

        // Parity values
        step(1, 1, MODE_LOAD, 8'h07, 0, 0, 8'h07, 0, 1, "par_load07");
        step(1, 1, MODE_SHL,  8'h00, 0, 1, 8'h0F, 1, 0, "par_shl");
        step(1, 1, MODE_HOLD, 8'hFF, 1, 0, 8'h0F, 1, 0, "hold");

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
